// File: rtl/io_pkg.sv
// Shared constants for the user I/O path: debounce defaults and the channel map
// that both io_in_debounce and the 4-bit user counter agree on.
package io_pkg;

   localparam int DEBOUNCE_CYCLES_DEFAULT = 10000;
   localparam int REPEAT_DELAY_DEFAULT    = 5000000;
   localparam int REPEAT_PERIOD_DEFAULT   = 1000000;

   localparam int CH_EN    = 0;
   localparam int CH_DIR   = 1;
   localparam int CH_LOAD  = 2;
   localparam int CH_SPARE = 3;

   typedef struct packed {
      logic level;
      logic rise;
      logic fall;
   } chan_out_t;

   function automatic int cntWidth(input int maxVal);
      return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
   endfunction

endpackage

// File: rtl/io_in_debounce_if.sv
// Pad-side bundle between the raw io_in bits and the conditioned level/pulse
// outputs consumed by the user counter.
interface io_in_debounce_if #(
   parameter int WIDTH = 4
);

   logic [WIDTH-1:0] btn_raw;
   logic [WIDTH-1:0] btn_level;
   logic [WIDTH-1:0] btn_rise;
   logic [WIDTH-1:0] btn_fall;

   modport master (
      output btn_raw,
      input  btn_level,
      input  btn_rise,
      input  btn_fall
   );

   modport slave (
      input  btn_raw,
      output btn_level,
      output btn_rise,
      output btn_fall
   );

endinterface

// File: rtl/io_in_debounce_channel.sv
// One input channel: 2-flop synchroniser, saturating debounce counter and
// registered edge pulses. Auto-repeat on btn_rise when IO_DEBOUNCE_REPEAT_EN is defined.
module debounce_channel
   import io_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
`ifdef IO_DEBOUNCE_REPEAT_EN
   ,
   parameter int REPEAT_DELAY    = REPEAT_DELAY_DEFAULT,
   parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEFAULT
`endif
) (
   input  logic      i_clk,
   input  logic      i_rst,
   input  logic      i_raw,
   output chan_out_t o_out
);

   localparam int CW = cntWidth(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          r_sync1;
   logic          r_syncQ;
   logic [CW-1:0] r_cnt;
   logic          r_level;
   logic          r_rise;
   logic          r_fall;
   logic          w_accept;
   logic          w_repHit;

   assign w_accept = (r_syncQ != r_level) && (r_cnt == CNT_LAST);

   // The counter only advances while the synchronised input disagrees with the
   // accepted level, so any glitch back to the old level restarts the count.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync1 <= 1'b0;
         r_syncQ <= 1'b0;
         r_cnt   <= '0;
         r_level <= 1'b0;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
      end else begin
         r_sync1 <= i_raw;
         r_syncQ <= r_sync1;
         r_rise  <= (w_accept & r_syncQ) | (w_repHit & ~w_accept);
         r_fall  <= w_accept & ~r_syncQ;
         if (r_syncQ == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_LAST) begin
            r_level <= r_syncQ;
            r_cnt   <= '0;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

`ifdef IO_DEBOUNCE_REPEAT_EN
   localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RW   = cntWidth(RMAX);
   localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

   logic [RW-1:0] r_repCnt;
   logic          r_repFirst;

   assign w_repHit = r_level &&
                     (r_repFirst ? (r_repCnt == DELAY_LAST) : (r_repCnt == PERIOD_LAST));

   // First repeat waits the long delay, later ones use the shorter period;
   // any acceptance (press or release) or a low level rearms the long delay.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_repCnt   <= '0;
         r_repFirst <= 1'b1;
      end else if (!r_level || w_accept) begin
         r_repCnt   <= '0;
         r_repFirst <= 1'b1;
      end else if (w_repHit) begin
         r_repCnt   <= '0;
         r_repFirst <= 1'b0;
      end else begin
         r_repCnt <= r_repCnt + RW'(1);
      end
   end
`else
   assign w_repHit = 1'b0;
`endif

   assign o_out.level = r_level;
   assign o_out.rise  = r_rise;
   assign o_out.fall  = r_fall;

endmodule

// File: rtl/io_in_debounce.sv
// Conditions WIDTH raw io_in pad bits into debounced levels and rise/fall strobes.
// Optional auto-repeat on btn_rise is enabled by defining IO_DEBOUNCE_REPEAT_EN.
module io_in_debounce
   import io_pkg::*;
#(
   parameter int WIDTH           = 4,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
   parameter int REPEAT_DELAY    = REPEAT_DELAY_DEFAULT,
   parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   io_in_debounce_if.slave  bus
);

   if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535 ||
       REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
      $error("io_in_debounce: parameter out of range");
   end

   chan_out_t        w_out [WIDTH];
   logic [WIDTH-1:0] w_level;
   logic [WIDTH-1:0] w_rise;
   logic [WIDTH-1:0] w_fall;

   for (genvar g = 0; g < WIDTH; g++) begin : g_ch
      debounce_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef IO_DEBOUNCE_REPEAT_EN
         ,
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
      ) u_ch (
         .i_clk (clk),
         .i_rst (rst),
         .i_raw (bus.btn_raw[g]),
         .o_out (w_out[g])
      );
   end

   always_comb begin
      w_level = '0;
      w_rise  = '0;
      w_fall  = '0;
      for (int i = 0; i < WIDTH; i++) begin
         w_level[i] = w_out[i].level;
         w_rise[i]  = w_out[i].rise;
         w_fall[i]  = w_out[i].fall;
      end
   end

   assign bus.btn_level = w_level;
   assign bus.btn_rise  = w_rise;
   assign bus.btn_fall  = w_fall;

endmodule

// File: tb/tb_io_in_debounce.sv
// Scoreboard bench for io_in_debounce with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10,
// REPEAT_PERIOD=3; repeat expectations follow IO_DEBOUNCE_REPEAT_EN.
module tb_io_in_debounce;

   typedef struct {
      int         cyc;
      logic [3:0] rise;
      logic [3:0] fall;
      logic [3:0] level;
   } exp_t;

   logic clk;
   logic rst;
   int   edgeCnt;
   int   vecCount;
   int   failCount;
   exp_t expQ[$];

   io_in_debounce_if #(.WIDTH(4)) bus ();

   io_in_debounce #(
      .WIDTH           (4),
      .DEBOUNCE_CYCLES (4),
      .REPEAT_DELAY    (10),
      .REPEAT_PERIOD   (3)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial edgeCnt = 0;
   always @(posedge clk) edgeCnt <= edgeCnt + 1;

   task automatic applyStimulus(input logic [3:0] raw);
      bus.btn_raw = raw;
   endtask

   task automatic expectPulse(input int cyc, input logic [3:0] rise,
                              input logic [3:0] fall, input logic [3:0] level);
      exp_t e;
      e.cyc   = cyc;
      e.rise  = rise;
      e.fall  = fall;
      e.level = level;
      expQ.push_back(e);
   endtask

   task automatic checkOutput(input string name, input logic [3:0] level,
                              input logic [3:0] rise, input logic [3:0] fall);
      vecCount++;
      if (bus.btn_level !== level || bus.btn_rise !== rise || bus.btn_fall !== fall) begin
         failCount++;
         $display("[TB] FAIL %s: got level=%b rise=%b fall=%b, want level=%b rise=%b fall=%b",
                  name, bus.btn_level, bus.btn_rise, bus.btn_fall, level, rise, fall);
      end
   endtask

   // Monitor: every observed pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if ((bus.btn_rise | bus.btn_fall) !== 4'b0000) begin
         vecCount++;
         if (expQ.size() == 0) begin
            failCount++;
            $display("[TB] FAIL unexpected pulse at edge %0d: rise=%b fall=%b level=%b",
                     edgeCnt, bus.btn_rise, bus.btn_fall, bus.btn_level);
         end else begin
            exp_t e;
            e = expQ.pop_front();
            if (e.cyc != edgeCnt || e.rise !== bus.btn_rise ||
                e.fall !== bus.btn_fall || e.level !== bus.btn_level) begin
               failCount++;
               $display("[TB] FAIL pulse: got edge=%0d rise=%b fall=%b level=%b, want edge=%0d rise=%b fall=%b level=%b",
                        edgeCnt, bus.btn_rise, bus.btn_fall, bus.btn_level,
                        e.cyc, e.rise, e.fall, e.level);
            end
         end
      end
   end

   initial begin
      int base;
      vecCount  = 0;
      failCount = 0;
      rst = 1'b1;
      applyStimulus(4'hF);

      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("reset hold", 4'h0, 4'h0, 4'h0);
      end
      rst = 1'b0;
      @(negedge clk);
      checkOutput("after reset", 4'h0, 4'h0, 4'h0);
      applyStimulus(4'h0);
      repeat (8) @(negedge clk);

      // Clean press on ch0, held long enough to exercise auto-repeat
      applyStimulus(4'b0001);
      base = edgeCnt;
      expectPulse(base + 6, 4'b0001, 4'b0000, 4'b0001);
`ifdef IO_DEBOUNCE_REPEAT_EN
      for (int k = 0; k < 7; k++)
         expectPulse(base + 16 + 3 * k, 4'b0001, 4'b0000, 4'b0001);
`endif
      repeat (31) @(negedge clk);
      applyStimulus(4'b0000);
      expectPulse(base + 37, 4'b0000, 4'b0001, 4'b0000);
      repeat (10) @(negedge clk);

      // Bounce on ch1: high runs of DEBOUNCE_CYCLES-1 must be rejected
      applyStimulus(4'b0010);
      repeat (3) @(negedge clk);
      applyStimulus(4'b0000);
      @(negedge clk);
      applyStimulus(4'b0010);
      repeat (3) @(negedge clk);
      applyStimulus(4'b0000);
      repeat (8) @(negedge clk);
      checkOutput("bounce rejected", 4'h0, 4'h0, 4'h0);

      // Press then release on ch2
      applyStimulus(4'b0100);
      base = edgeCnt;
      expectPulse(base + 6, 4'b0100, 4'b0000, 4'b0100);
      repeat (8) @(negedge clk);
      applyStimulus(4'b0000);
      expectPulse(base + 14, 4'b0000, 4'b0100, 4'b0000);
      repeat (10) @(negedge clk);

      // Reset in the middle of a ch3 count
      applyStimulus(4'b1000);
      base = edgeCnt;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("mid-count reset", 4'h0, 4'h0, 4'h0);
      expectPulse(base + 10, 4'b1000, 4'b0000, 4'b1000);
      repeat (8) @(negedge clk);
      applyStimulus(4'b0000);
      expectPulse(base + 18, 4'b0000, 4'b1000, 4'b0000);
      repeat (10) @(negedge clk);
      checkOutput("final idle", 4'h0, 4'h0, 4'h0);

      while (expQ.size() > 0) begin
         exp_t e;
         e = expQ.pop_front();
         vecCount++;
         failCount++;
         $display("[TB] FAIL missing pulse: got none, want edge=%0d rise=%b fall=%b",
                  e.cyc, e.rise, e.fall);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, failCount);
      $finish;
   end

endmodule
